// File: rtl/game_vga_timing.sv
// Free-running VGA timing generator: pixel clock-enable divider, h/v counters and registered sync/coords.
// Optional frame counter is built when GAME_VGA_FRAME_COUNTER_EN is defined; otherwise frame_count is tied to zero.
module game_vga_timing #(
    parameter int clk_mhz       = 50,
    parameter int pixel_mhz     = 25,
    parameter int screen_width  = 640,
    parameter int screen_height = 480,
    parameter int h_front       = 16,
    parameter int h_sync        = 96,
    parameter int h_back        = 48,
    parameter int v_front       = 10,
    parameter int v_sync        = 2,
    parameter int v_back        = 33,
    parameter int w_x           = $clog2(screen_width),
    parameter int w_y           = $clog2(screen_height)
) (
    input  logic           clk,
    input  logic           rst,
    output logic           pixel_strobe,
    output logic           hsync,
    output logic           vsync,
    output logic           display_on,
    output logic [w_x-1:0] x,
    output logic [w_y-1:0] y,
    output logic           frame_start,
    output logic [15:0]    frame_count
);

    localparam int DIV     = clk_mhz / pixel_mhz;
    localparam int W_D     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int H_TOTAL = screen_width + h_front + h_sync + h_back;
    localparam int V_TOTAL = screen_height + v_front + v_sync + v_back;
    localparam int W_H     = $clog2(H_TOTAL + 1);
    localparam int W_V     = $clog2(V_TOTAL + 1);

    localparam logic [W_D-1:0] DIV_LAST = W_D'(DIV - 1);
    localparam logic [W_H-1:0] H_LAST   = W_H'(H_TOTAL - 1);
    localparam logic [W_V-1:0] V_LAST   = W_V'(V_TOTAL - 1);
    localparam logic [W_H-1:0] H_ACT    = W_H'(screen_width);
    localparam logic [W_V-1:0] V_ACT    = W_V'(screen_height);
    localparam logic [W_H-1:0] HS_BEG   = W_H'(screen_width + h_front);
    localparam logic [W_H-1:0] HS_END   = W_H'(screen_width + h_front + h_sync);
    localparam logic [W_V-1:0] VS_BEG   = W_V'(screen_height + v_front);
    localparam logic [W_V-1:0] VS_END   = W_V'(screen_height + v_front + v_sync);

    logic [W_D-1:0] div_q, div_d;
    logic [W_H-1:0] h_q, h_d;
    logic [W_V-1:0] v_q, v_d;
    logic           tick;

    logic           strobe_q, hs_q, vs_q, on_q, fs_q;
    logic           hs_d, vs_d, on_d, fs_d;
    logic [w_x-1:0] x_q, x_d;
    logic [w_y-1:0] y_q, y_d;

    // Counter next-state; with DIV=1 div_q stays 0 and tick is always high.
    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        if (tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Outputs are decoded from the next-state counters so the flops line up with h_q/v_q.
    always_comb begin
        on_d = (h_d < H_ACT) && (v_d < V_ACT);
        x_d  = on_d ? h_d[w_x-1:0] : '0;
        y_d  = on_d ? v_d[w_y-1:0] : '0;
        hs_d = !((h_d >= HS_BEG) && (h_d < HS_END));
        vs_d = !((v_d >= VS_BEG) && (v_d < VS_END));
        fs_d = tick && (h_d == '0) && (v_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            h_q      <= H_LAST;
            v_q      <= V_LAST;
            strobe_q <= 1'b0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            on_q     <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            fs_q     <= 1'b0;
        end else begin
            div_q    <= div_d;
            h_q      <= h_d;
            v_q      <= v_d;
            strobe_q <= tick;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            on_q     <= on_d;
            x_q      <= x_d;
            y_q      <= y_d;
            fs_q     <= fs_d;
        end
    end

`ifdef GAME_VGA_FRAME_COUNTER_EN
    logic [15:0] fc_q;

    // Increments on the same edge frame_start rises, so a new frame already reads its own number.
    always_ff @(posedge clk) begin
        if (rst) begin
            fc_q <= 16'h0000;
        end else if (fs_d) begin
            fc_q <= fc_q + 16'd1;
        end
    end

    assign frame_count = fc_q;
`else
    assign frame_count = 16'h0000;
`endif

    assign pixel_strobe = strobe_q;
    assign hsync        = hs_q;
    assign vsync        = vs_q;
    assign display_on   = on_q;
    assign x            = x_q;
    assign y            = y_q;
    assign frame_start  = fs_q;

endmodule

// File: tb/tb_game_vga_timing.sv
// Bench for game_vga_timing: three instances (default 640x480 DIV=2, small DIV=2, small DIV=1)
// checked every cycle against an arithmetic model driven by clocks elapsed since reset release.
module tb_game_vga_timing;

    // Small geometries keep full frames well inside the simulation budget.
    localparam int B_W = 8, B_H = 4, B_HF = 2, B_HS = 3, B_HB = 2, B_VF = 1, B_VS = 2, B_VB = 1;
    localparam int C_W = 6, C_H = 3, C_HF = 1, C_HS = 2, C_HB = 1, C_VF = 1, C_VS = 1, C_VB = 1;

    typedef struct packed {
        logic        strobe;
        logic        hs;
        logic        vs;
        logic        on;
        logic [15:0] x;
        logic [15:0] y;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    int   n_a = 0, n_b = 0, n_c = 0;
    int   errors = 0;
    int   checks = 0;

    logic       ps_a, hs_a, vs_a, on_a, fs_a;
    logic [9:0] x_a;
    logic [8:0] y_a;
    logic [15:0] fc_a;
    logic       ps_b, hs_b, vs_b, on_b, fs_b;
    logic [2:0] x_b;
    logic [1:0] y_b;
    logic [15:0] fc_b;
    logic       ps_c, hs_c, vs_c, on_c, fs_c;
    logic [2:0] x_c;
    logic [1:0] y_c;
    logic [15:0] fc_c;

    always #5 clk = ~clk;

    game_vga_timing dut_a (
        .clk(clk), .rst(rst_a), .pixel_strobe(ps_a), .hsync(hs_a), .vsync(vs_a),
        .display_on(on_a), .x(x_a), .y(y_a), .frame_start(fs_a), .frame_count(fc_a)
    );

    game_vga_timing #(
        .clk_mhz(50), .pixel_mhz(25), .screen_width(B_W), .screen_height(B_H),
        .h_front(B_HF), .h_sync(B_HS), .h_back(B_HB), .v_front(B_VF), .v_sync(B_VS), .v_back(B_VB)
    ) dut_b (
        .clk(clk), .rst(rst_b), .pixel_strobe(ps_b), .hsync(hs_b), .vsync(vs_b),
        .display_on(on_b), .x(x_b), .y(y_b), .frame_start(fs_b), .frame_count(fc_b)
    );

    game_vga_timing #(
        .clk_mhz(25), .pixel_mhz(25), .screen_width(C_W), .screen_height(C_H),
        .h_front(C_HF), .h_sync(C_HS), .h_back(C_HB), .v_front(C_VF), .v_sync(C_VS), .v_back(C_VB)
    ) dut_c (
        .clk(clk), .rst(rst_c), .pixel_strobe(ps_c), .hsync(hs_c), .vsync(vs_c),
        .display_on(on_c), .x(x_c), .y(y_c), .frame_start(fs_c), .frame_count(fc_c)
    );

    // n = clock edges seen with reset low since the last reset edge.
    // Pixel index s = n/div; screen position is that many pixels after the last pixel of a frame.
    function automatic exp_t model(int n, int div, int w, int h, int hf, int hsw, int hb,
                                   int vf, int vsw, int vb);
        exp_t e;
        int ht, vt, f, s, pos, hc, vc;
        ht  = w + hf + hsw + hb;
        vt  = h + vf + vsw + vb;
        f   = ht * vt;
        s   = n / div;
        pos = (s + f - 1) % f;
        hc  = pos % ht;
        vc  = pos / ht;
        e.strobe = (n > 0) && (n % div == 0);
        e.on     = (hc < w) && (vc < h);
        e.x      = e.on ? 16'(hc) : 16'd0;
        e.y      = e.on ? 16'(vc) : 16'd0;
        e.hs     = !((hc >= w + hf) && (hc < w + hf + hsw));
        e.vs     = !((vc >= h + vf) && (vc < h + vf + vsw));
        e.fs     = e.strobe && (pos == 0);
`ifdef GAME_VGA_FRAME_COUNTER_EN
        e.fc     = (s >= 1) ? 16'((s - 1) / f + 1) : 16'd0;
`else
        e.fc     = 16'd0;
`endif
        return e;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_dut(input string name, input exp_t e, input logic ps, input logic hs,
                             input logic vs, input logic on, input logic [15:0] xo,
                             input logic [15:0] yo, input logic fs, input logic [15:0] fc);
        check({name, ".pixel_strobe"}, 16'(ps), 16'(e.strobe));
        check({name, ".hsync"},        16'(hs), 16'(e.hs));
        check({name, ".vsync"},        16'(vs), 16'(e.vs));
        check({name, ".display_on"},   16'(on), 16'(e.on));
        check({name, ".x"},            xo,      e.x);
        check({name, ".y"},            yo,      e.y);
        check({name, ".frame_start"},  16'(fs), 16'(e.fs));
        check({name, ".frame_count"},  fc,      e.fc);
    endtask

    // Drive resets at the falling edge, clock once, then check all three instances at the next falling edge.
    task automatic cycle(input logic ra, input logic rb, input logic rc);
        rst_a = ra;
        rst_b = rb;
        rst_c = rc;
        @(posedge clk);
        n_a = ra ? 0 : n_a + 1;
        n_b = rb ? 0 : n_b + 1;
        n_c = rc ? 0 : n_c + 1;
        @(negedge clk);
        check_dut("a", model(n_a, 2, 640, 480, 16, 96, 48, 10, 2, 33),
                  ps_a, hs_a, vs_a, on_a, 16'(x_a), 16'(y_a), fs_a, fc_a);
        check_dut("b", model(n_b, 2, B_W, B_H, B_HF, B_HS, B_HB, B_VF, B_VS, B_VB),
                  ps_b, hs_b, vs_b, on_b, 16'(x_b), 16'(y_b), fs_b, fc_b);
        check_dut("c", model(n_c, 1, C_W, C_H, C_HF, C_HS, C_HB, C_VF, C_VS, C_VB),
                  ps_c, hs_c, vs_c, on_c, 16'(x_c), 16'(y_c), fs_c, fc_c);
    endtask

    initial begin
        int rb_left;
        int rc_left;
        rb_left = 0;
        rc_left = 0;
        @(negedge clk);

        // Hold everything in reset for 5 clocks.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1);

        // Release together; free-run long enough for several small frames.
        for (int i = 0; i < 1000; i++) cycle(1'b0, 1'b0, 1'b0);

        // Default mode runs two full lines plus margin; small instances get random mid-frame resets.
        for (int i = 0; i < 3400; i++) begin
            if (rb_left == 0 && $urandom_range(0, 199) == 0) rb_left = $urandom_range(1, 3);
            if (rc_left == 0 && $urandom_range(0, 149) == 0) rc_left = $urandom_range(1, 3);
            cycle(1'b0, rb_left > 0, rc_left > 0);
            if (rb_left > 0) rb_left--;
            if (rc_left > 0) rc_left--;
        end

        // Single-clock reset pulse on every instance mid-run, then recovery.
        cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 600; i++) cycle(1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_vga_timing.md
Name: game_vga_timing

Overview:
- Display timing generator that drives the pixel-coordinate side of the game pipeline.
- Produces x, y and display_on, which the game logic consumes to return rgb, plus hsync/vsync for the monitor.
- Derives the pixel rate from the system clock with a clock-enable divider; all logic runs on clk.
- Default mode is 640x480@60 (800x525 total).

Parameters:
- clk_mhz, 50, system clock frequency; clk_mhz/pixel_mhz must be an integer >= 1 (DIV).
- pixel_mhz, 25, pixel rate.
- screen_width, 640, active pixels per line.
- screen_height, 480, active lines per frame.
- h_front, 16; h_sync, 96; h_back, 48, horizontal porch/sync widths in pixels.
- v_front, 10; v_sync, 2; v_back, 33, vertical porch/sync widths in lines.
- w_x, $clog2(screen_width), x output width.
- w_y, $clog2(screen_height), y output width.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset.
- pixel_strobe  output  1  one-clk pulse per pixel advance.
- hsync  output  1  horizontal sync, active low.
- vsync  output  1  vertical sync, active low.
- display_on  output  1  high inside the active area.
- x  output  w_x  active-area column.
- y  output  w_y  active-area row.
- frame_start  output  1  one-clk pulse on entry to pixel (0,0).
- frame_count  output  16  frames started (see Optional Feature).

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Totals: H_TOTAL = screen_width + h_front + h_sync + h_back (800). V_TOTAL = screen_height + v_front + v_sync + v_back (525).
- Internal counters:
  - div_cnt: 0..DIV-1, increments every clk, wraps to 0. tick = (div_cnt == DIV-1); with DIV=1, tick is constant 1.
  - h_cnt: 0..H_TOTAL-1, advances on tick, wraps to 0.
  - v_cnt: 0..V_TOTAL-1, advances on tick when h_cnt wraps, wraps to 0.
- Reset state (on any clk edge with rst=1, including mid-frame): div_cnt=0, h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1, i.e. the last pixel of a frame. Outputs at reset:
  - pixel_strobe=0, hsync=1, vsync=1, display_on=0
  - x=0, y=0, frame_start=0, frame_count=0
- After reset release, the first tick moves the counters to (0,0).
- All outputs are flops, computed from next-state counters, so they always match the current h_cnt/v_cnt with zero lag:
  - display_on = (h_cnt < screen_width) && (v_cnt < screen_height).
  - x = h_cnt and y = v_cnt when display_on; otherwise both are 0.
  - hsync = 0 iff screen_width+h_front <= h_cnt < screen_width+h_front+h_sync (656..751).
  - vsync = 0 iff screen_height+v_front <= v_cnt < screen_height+v_front+v_sync (490..491).
  - pixel_strobe = 1 for exactly the first clk cycle after each counter update; low for DIV-1 cycles between pulses. High every cycle when DIV=1.
  - frame_start = 1 in the same cycle as pixel_strobe when the counters have just entered (0,0).
- Each pixel's x/y/display_on/hsync/vsync are held for DIV clk cycles.
- Line period is H_TOTAL*DIV clks (1600); frame period is H_TOTAL*V_TOTAL*DIV clks (840000).
- Simultaneous h and v wrap on the last pixel: both go to 0 on the same tick; frame_start fires.
- No inputs other than clk/rst; behaviour is fully free-running.

Optional Feature:
- Macro: GAME_VGA_FRAME_COUNTER_EN.
- Defined: frame_count is a 16-bit register, incremented in the cycle frame_start is asserted. It wraps 0xFFFF -> 0x0000 and is cleared by rst. The first frame after reset reads 1 while it is displayed.
- Undefined: frame_count is tied to 16'h0000 and no counter flops exist.
- The port is present in both builds.

Test Plan:
- Reset check: hold rst 5 clks, then release -> during rst all outputs hold reset values. First pixel_strobe arrives DIV=2 clks after release with x=0, y=0, display_on=1, frame_start=1.
- Pixel strobe cadence: run one line -> pixel_strobe pulses every 2 clks. x counts 0..639 over 1280 clks, then display_on=0 and x=0 for 320 clks.
- Horizontal sync: hsync low for exactly 192 clks, starting 16 pixels (32 clks) after display_on falls; line period 1600 clks.
- Frame timing: run 2 frames -> vsync low for 2 lines (3200 clks) starting at line 490. frame_start pulses exactly 840000 clks apart. y reaches 479 and never exceeds it.
- Mid-frame reset: assert rst at x=300, y=200 for 1 clk -> outputs return to reset values next edge; the next frame_start is 2 clks after release.
- DIV=1 build (clk_mhz=25): pixel_strobe constantly 1, line period 800 clks. With GAME_VGA_FRAME_COUNTER_EN defined, frame_count = 3 after 3 frame_start pulses; without it, frame_count stays 0.
